mult_booth_seq: RTL and testbench

Sequential radix-4 (modified Booth) signed 32×32 multiplier for the multdiv unit. It accepts a start pulse with the multiplicand and multiplier and iterates for 16 cycles. It then presents the 64-bit two's-complement product as `product_left` (high word) and `product_right` (low word) with a one-cycle `result_ready` strobe. Its outputs, together with the captured operands, feed the downstream overflow/exception checker directly.

---
 rtl/mult_booth_seq.sv | 121 ++++++++++++
 tb/tb_mult_booth_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mult_booth_seq.sv
// Sequential radix-4 (modified Booth) signed 32x32 multiplier, 16 iterations per product.
// Optional build macro MULT_EARLY_ZERO_EN: a zero operand skips iteration and strobes a zero product early.
module mult_booth_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_mult,
    input  logic [31:0] mc,
    input  logic [31:0] mp,
    output logic [31:0] mc_q,
    output logic [31:0] mp_q,
    output logic [31:0] product_left,
    output logic [31:0] product_right,
    output logic        result_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [66:0] acc_q, acc_d;
    logic [31:0] mc_d, mp_d;
    logic [31:0] prod_hi_q, prod_hi_d;
    logic [31:0] prod_lo_q, prod_lo_d;
    logic        zero_pend_q, zero_pend_d;

    logic [33:0] m_pos, m_pos2, m_neg, m_neg2, addend, hi_sum;
    logic [66:0] pre_shift;

    always_comb begin
        m_pos  = {{2{mc_q[31]}}, mc_q};
        m_pos2 = {m_pos[32:0], 1'b0};
        m_neg  = ~m_pos + 34'd1;
        m_neg2 = ~m_pos2 + 34'd1;
        case (acc_q[2:0])
            3'b001, 3'b010: addend = m_pos;
            3'b011:         addend = m_pos2;
            3'b100:         addend = m_neg2;
            3'b101, 3'b110: addend = m_neg;
            default:        addend = 34'd0;
        endcase
        hi_sum    = acc_q[66:33] + addend;
        pre_shift = {hi_sum, acc_q[32:0]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mc_d        = mc_q;
        mp_d        = mp_q;
        prod_hi_d   = prod_hi_q;
        prod_lo_d   = prod_lo_q;
        zero_pend_d = 1'b0;
        if (ctrl_mult) begin
            acc_d   = {34'd0, mp, 1'b0};
            mc_d    = mc;
            mp_d    = mp;
            cnt_d   = 4'd0;
            state_d = ST_RUN;
`ifdef MULT_EARLY_ZERO_EN
            // Park in IDLE for one cycle so the zero-product strobe lands after the next edge.
            if ((mc == 32'd0) || (mp == 32'd0)) begin
                state_d     = ST_IDLE;
                zero_pend_d = 1'b1;
                prod_hi_d   = 32'd0;
                prod_lo_d   = 32'd0;
            end
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (zero_pend_q) state_d = ST_DONE;
                end
                ST_RUN: begin
                    acc_d = {{2{pre_shift[66]}}, pre_shift[66:2]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        prod_hi_d = acc_d[64:33];
                        prod_lo_d = acc_d[32:1];
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= 67'd0;
            mc_q        <= 32'd0;
            mp_q        <= 32'd0;
            prod_hi_q   <= 32'd0;
            prod_lo_q   <= 32'd0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mc_q        <= mc_d;
            mp_q        <= mp_d;
            prod_hi_q   <= prod_hi_d;
            prod_lo_q   <= prod_lo_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign product_left  = prod_hi_q;
    assign product_right = prod_lo_q;
    assign result_ready  = (state_q == ST_DONE);
    assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed self-checking bench for mult_booth_seq; honours MULT_EARLY_ZERO_EN when defined.
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_mult = 1'b0;
    logic [31:0] mc = 32'd0;
    logic [31:0] mp = 32'd0;
    logic [31:0] mc_q, mp_q, product_left, product_right;
    logic        result_ready, busy;

    int errors = 0;
    int checks = 0;
    int lat;
    int strobes;

    always #5 clock = ~clock;

    mult_booth_seq dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ctrl_mult    (ctrl_mult),
        .mc           (mc),
        .mp           (mp),
        .mc_q         (mc_q),
        .mp_q         (mp_q),
        .product_left (product_left),
        .product_right(product_right),
        .result_ready (result_ready),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse a start, then count edges after the load edge until result_ready, bounded.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat, input logic exp_busy, input logic [63:0] exp_p);
        ctrl_mult = 1'b1;
        mc = a;
        mp = b;
        tick();
        ctrl_mult = 1'b0;
        mc = 32'hDEAD_BEEF;
        mp = 32'hCAFE_F00D;
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, exp_busy});
        lat = 0;
        while (!result_ready && lat < 40) begin
            tick();
            lat++;
            if (busy && result_ready) check({tag, "_excl"}, 64'd1, 64'd0);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prod"}, {product_left, product_right}, exp_p);
        check({tag, "_ops"}, {mc_q, mp_q}, {a, b});
        tick();
        check({tag, "_strobe1"}, {62'd0, result_ready, busy}, 64'd0);
    endtask

    initial begin
        tick();
        tick();
        check("reset_out", {product_left, product_right}, 64'd0);
        check("reset_ops", {mc_q, mp_q}, 64'd0);
        check("reset_flags", {62'd0, result_ready, busy}, 64'd0);
        reset_n = 1'b1;
        tick();

        run_mult("b3x5", 32'd3, 32'd5, 16, 1'b1, 64'h0000_0000_0000_000F);
        run_mult("neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16, 1'b1, 64'h0000_0000_0000_0001);
        run_mult("neg3x7", 32'hFFFF_FFFD, 32'd7, 16, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mult("min2", 32'h8000_0000, 32'h8000_0000, 16, 1'b1, 64'h4000_0000_0000_0000);
        run_mult("max2", 32'h7FFF_FFFF, 32'd2, 16, 1'b1, 64'h0000_0000_FFFF_FFFE);
        run_mult("negbig", 32'h1234_5678, 32'hFFFF_FFFF, 16, 1'b1, 64'hFFFF_FFFF_EDCB_A988);

        // Restart: 3x5 aborted at edge 8 by 6x7; previous product must hold meanwhile.
        ctrl_mult = 1'b1;
        mc = 32'd3;
        mp = 32'd5;
        tick();
        ctrl_mult = 1'b0;
        strobes = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (result_ready) strobes++;
        end
        check("rst_hold", {product_left, product_right}, 64'hFFFF_FFFF_EDCB_A988);
        check("rst_nostrobe", strobes, 0);
        run_mult("restart", 32'd6, 32'd7, 16, 1'b1, 64'd42);

        // Synchronous reset applied on the fifth edge of a run.
        ctrl_mult = 1'b1;
        mc = 32'd9;
        mp = 32'd9;
        tick();
        ctrl_mult = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_prod", {product_left, product_right}, 64'd0);
        check("midrst_ops", {mc_q, mp_q}, 64'd0);
        check("midrst_flags", {62'd0, result_ready, busy}, 64'd0);
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_ready || busy) strobes++;
        end
        check("midrst_quiet", strobes, 0);
        run_mult("post2x2", 32'd2, 32'd2, 16, 1'b1, 64'd4);

`ifdef MULT_EARLY_ZERO_EN
        run_mult("zero", 32'd0, 32'h1234_5678, 1, 1'b0, 64'd0);
`else
        run_mult("zero", 32'd0, 32'h1234_5678, 16, 1'b1, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
